// File: rtl/cache_pkg.sv
// Shared types and defaults for the cache bus arbiter.
package cache_pkg;

    localparam int BCNT_WIDTH_DEF = 8;
    localparam int NUM_REQ        = 2;

    typedef enum logic [1:0] {
        IDLE,
        WR_BURST,
        RD_CMD,
        RD_DATA
    } arb_state_e;

endpackage

// File: rtl/cache_arb_beat_cnt.sv
// Burst beat counter: loadable length, increment, last-beat flag, synchronous clear.
module cache_arb_beat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic [W-1:0] len_in,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         last
);

    logic [W-1:0] len_reg;
    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            len_reg <= W'(1);
            cnt_reg <= '0;
        end else if (load) begin
            len_reg <= len_in;
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc) begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign cnt  = cnt_reg;
    assign last = (cnt_reg == len_reg - W'(1));

endmodule

// File: rtl/cache_bus_arb.sv
// Two-requester Avalon burst arbiter; the grant is held for a whole burst.
// Define CACHE_ARB_RR_EN for round-robin tie-break, otherwise s0 always wins ties.
module cache_bus_arb
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BCNT_WIDTH = BCNT_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rest,
    input  logic [ADDR_WIDTH-1:0]   s0_address,
    input  logic [DATA_WIDTH/8-1:0] s0_byteEnable,
    input  logic                    s0_read,
    input  logic                    s0_write,
    input  logic [DATA_WIDTH-1:0]   s0_writeData,
    input  logic                    s0_beginBurstTransfer,
    input  logic [BCNT_WIDTH-1:0]   s0_burstCount,
    output logic                    s0_waitRequest,
    output logic [DATA_WIDTH-1:0]   s0_readData,
    output logic                    s0_readDataValid,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic [DATA_WIDTH/8-1:0] s1_byteEnable,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH-1:0]   s1_writeData,
    input  logic                    s1_beginBurstTransfer,
    input  logic [BCNT_WIDTH-1:0]   s1_burstCount,
    output logic                    s1_waitRequest,
    output logic [DATA_WIDTH-1:0]   s1_readData,
    output logic                    s1_readDataValid,
    output logic [ADDR_WIDTH-1:0]   m0_address,
    output logic [DATA_WIDTH/8-1:0] m0_byteEnable,
    output logic                    m0_read,
    output logic                    m0_write,
    output logic [DATA_WIDTH-1:0]   m0_writeData,
    output logic                    m0_beginBurstTransfer,
    output logic [BCNT_WIDTH-1:0]   m0_burstCount,
    input  logic                    m0_waitRequest,
    input  logic [DATA_WIDTH-1:0]   m0_readData,
    input  logic                    m0_readDataValid
);

    logic [ADDR_WIDTH-1:0]   s_address [NUM_REQ];
    logic [DATA_WIDTH/8-1:0] s_byte_en [NUM_REQ];
    logic [DATA_WIDTH-1:0]   s_wdata   [NUM_REQ];
    logic [BCNT_WIDTH-1:0]   s_bcnt    [NUM_REQ];
    logic [NUM_REQ-1:0]      s_read, s_write, s_begin, req;
    logic [NUM_REQ-1:0]      wait_vec, rdv_vec;

    assign s_address = '{s0_address, s1_address};
    assign s_byte_en = '{s0_byteEnable, s1_byteEnable};
    assign s_wdata   = '{s0_writeData, s1_writeData};
    assign s_bcnt    = '{s0_burstCount, s1_burstCount};
    assign s_read    = {s1_read, s0_read};
    assign s_write   = {s1_write, s0_write};
    assign s_begin   = {s1_beginBurstTransfer, s0_beginBurstTransfer};

    arb_state_e state_reg, state_next;
    logic       owner_reg, owner_next;
    logic       pick;
    logic       cnt_load, cnt_inc, cnt_clr, cnt_last;
    logic       burst_done;
    logic       cmd_phase;
    logic [BCNT_WIDTH-1:0] cnt_val, load_len;

    assign cmd_phase = (state_reg == WR_BURST) || (state_reg == RD_CMD);

`ifdef CACHE_ARB_RR_EN
    logic rr_last_reg;

    always_ff @(posedge clk) begin
        if (rest) begin
            rr_last_reg <= 1'b1;
        end else if (burst_done) begin
            rr_last_reg <= owner_reg;
        end
    end

    assign pick = (req == 2'b11) ? ~rr_last_reg : ~req[0];
`else
    assign pick = ~req[0];
`endif

    assign load_len = (s_bcnt[pick] == '0) ? BCNT_WIDTH'(1) : s_bcnt[pick];

    always_ff @(posedge clk) begin
        if (rest) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        burst_done = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    owner_next = pick;
                    cnt_load   = 1'b1;
                    // Write takes precedence when a requester raises both strobes.
                    state_next = s_write[pick] ? WR_BURST : RD_CMD;
                end
            end
            WR_BURST: begin
                if (m0_write && !m0_waitRequest) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        state_next = IDLE;
                        cnt_clr    = 1'b1;
                        burst_done = 1'b1;
                    end
                end
            end
            RD_CMD: begin
                if (m0_read && !m0_waitRequest) begin
                    state_next = RD_DATA;
                    cnt_clr    = 1'b1;
                end
            end
            RD_DATA: begin
                if (m0_readDataValid) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        state_next = IDLE;
                        cnt_clr    = 1'b1;
                        burst_done = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    cache_arb_beat_cnt #(.W(BCNT_WIDTH)) u_beat_cnt (
        .clk    (clk),
        .srst   (rest),
        .load   (cnt_load),
        .len_in (load_len),
        .inc    (cnt_inc),
        .clr    (cnt_clr),
        .cnt    (cnt_val),
        .last   (cnt_last)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req[gi]      = s_read[gi] | s_write[gi];
            assign wait_vec[gi] = (cmd_phase && (owner_reg == gi)) ? m0_waitRequest : 1'b1;
            assign rdv_vec[gi]  = (state_reg == RD_DATA) && (owner_reg == gi) && m0_readDataValid;
        end
    endgenerate

    assign s0_waitRequest   = wait_vec[0];
    assign s1_waitRequest   = wait_vec[1];
    assign s0_readDataValid = rdv_vec[0];
    assign s1_readDataValid = rdv_vec[1];
    assign s0_readData      = m0_readData;
    assign s1_readData      = m0_readData;

    always_comb begin
        m0_address            = '0;
        m0_byteEnable         = '0;
        m0_read               = 1'b0;
        m0_write              = 1'b0;
        m0_writeData          = '0;
        m0_beginBurstTransfer = 1'b0;
        m0_burstCount         = '0;
        if (cmd_phase) begin
            m0_address            = s_address[owner_reg];
            m0_byteEnable         = s_byte_en[owner_reg];
            m0_read               = s_read[owner_reg];
            m0_write              = s_write[owner_reg];
            m0_writeData          = s_wdata[owner_reg];
            m0_beginBurstTransfer = s_begin[owner_reg] && (cnt_val == '0);
            m0_burstCount         = s_bcnt[owner_reg];
        end
    end

endmodule

// File: tb/tb_cache_bus_arb.sv
// Randomized bench for cache_bus_arb against a burst-level reference model.
module tb_cache_bus_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 8;

    logic clk = 1'b0;
    logic rest = 1'b1;

    logic [AW-1:0]   s_addr [2];
    logic [DW/8-1:0] s_be   [2];
    logic [DW-1:0]   s_wd   [2];
    logic [BW-1:0]   s_bc   [2];
    logic [1:0]      s_rd, s_wr, s_beg;
    logic [1:0]      s_wait, s_rdv;
    logic [DW-1:0]   s0_rdata, s1_rdata;

    logic [AW-1:0]   m0_address;
    logic [DW/8-1:0] m0_byteEnable;
    logic            m0_read, m0_write, m0_beginBurstTransfer;
    logic [DW-1:0]   m0_writeData;
    logic [BW-1:0]   m0_burstCount;
    logic            m0_wait, m0_rdv;
    logic [DW-1:0]   m0_rdata;

    int total = 0;
    int bad   = 0;

    cache_bus_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BCNT_WIDTH(BW)) dut (
        .clk                   (clk),
        .rest                  (rest),
        .s0_address            (s_addr[0]),
        .s0_byteEnable         (s_be[0]),
        .s0_read               (s_rd[0]),
        .s0_write              (s_wr[0]),
        .s0_writeData          (s_wd[0]),
        .s0_beginBurstTransfer (s_beg[0]),
        .s0_burstCount         (s_bc[0]),
        .s0_waitRequest        (s_wait[0]),
        .s0_readData           (s0_rdata),
        .s0_readDataValid      (s_rdv[0]),
        .s1_address            (s_addr[1]),
        .s1_byteEnable         (s_be[1]),
        .s1_read               (s_rd[1]),
        .s1_write              (s_wr[1]),
        .s1_writeData          (s_wd[1]),
        .s1_beginBurstTransfer (s_beg[1]),
        .s1_burstCount         (s_bc[1]),
        .s1_waitRequest        (s_wait[1]),
        .s1_readData           (s1_rdata),
        .s1_readDataValid      (s_rdv[1]),
        .m0_address            (m0_address),
        .m0_byteEnable         (m0_byteEnable),
        .m0_read               (m0_read),
        .m0_write              (m0_write),
        .m0_writeData          (m0_writeData),
        .m0_beginBurstTransfer (m0_beginBurstTransfer),
        .m0_burstCount         (m0_burstCount),
        .m0_waitRequest        (m0_wait),
        .m0_readData           (m0_rdata),
        .m0_readDataValid      (m0_rdv)
    );

    always #5 clk = ~clk;

    // Reference model: a burst is "busy" with an owner, a total beat count and beats done.
    bit busy = 0;
    int own = 0;
    bit is_wr = 0;
    bit cmd_ph = 0;
    int beats_total = 0;
    int beats_done = 0;
    int rr_last = 1;
    int grants [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic finish_burst();
        $display("burst owner=s%0d %s beats=%0d", own, is_wr ? "write" : "read", beats_total);
        busy = 0;
        rr_last = own;
    endtask

    task automatic compare_outputs();
        logic [78:0] cmd_exp, cmd_obs;
        logic [67:0] rsp_exp, rsp_obs;
        logic [1:0]  w_exp, v_exp;
        w_exp   = 2'b11;
        v_exp   = 2'b00;
        cmd_exp = '0;
        if (busy && (is_wr || cmd_ph)) begin
            cmd_exp = {s_addr[own], s_be[own], s_rd[own], s_wr[own], s_wd[own],
                       s_beg[own] && (beats_done == 0), s_bc[own]};
            w_exp[own] = m0_wait;
        end else if (busy) begin
            v_exp[own] = m0_rdv;
        end
        rsp_exp = {w_exp, v_exp, m0_rdata, m0_rdata};
        cmd_obs = {m0_address, m0_byteEnable, m0_read, m0_write, m0_writeData,
                   m0_beginBurstTransfer, m0_burstCount};
        rsp_obs = {s_wait, s_rdv, s0_rdata, s1_rdata};
        chk("m0_cmd", 128'(cmd_obs), 128'(cmd_exp));
        chk("s_resp", 128'(rsp_obs), 128'(rsp_exp));
        if (m0_write && m0_beginBurstTransfer && !m0_wait)
            grants.push_back(s_wait[0] ? 1 : 0);
    endtask

    task automatic model_step();
        bit r0, r1;
        r0 = s_rd[0] | s_wr[0];
        r1 = s_rd[1] | s_wr[1];
        if (rest) begin
            busy = 0;
            beats_done = 0;
            rr_last = 1;
        end else if (!busy) begin
            if (r0 || r1) begin
`ifdef CACHE_ARB_RR_EN
                if (r0 && r1) own = 1 - rr_last;
`else
                if (r0 && r1) own = 0;
`endif
                else own = r0 ? 0 : 1;
                busy = 1;
                is_wr = s_wr[own];
                cmd_ph = !is_wr;
                beats_total = (s_bc[own] == 0) ? 1 : int'(s_bc[own]);
                beats_done = 0;
            end
        end else if (is_wr) begin
            if (s_wr[own] && !m0_wait) begin
                beats_done++;
                if (beats_done == beats_total) finish_burst();
            end
        end else if (cmd_ph) begin
            if (s_rd[own] && !m0_wait) cmd_ph = 0;
        end else if (m0_rdv) begin
            beats_done++;
            if (beats_done == beats_total) finish_burst();
        end
    endtask

    task automatic drive_random(input int rst_odds);
        for (int i = 0; i < 2; i++) begin
            s_addr[i] = $urandom;
            s_be[i]   = 4'($urandom);
            s_wd[i]   = $urandom;
            s_bc[i]   = 8'($urandom_range(0, 6));
            s_rd[i]   = ($urandom_range(0, 3) == 0);
            s_wr[i]   = ($urandom_range(0, 2) == 0);
            s_beg[i]  = 1'($urandom);
        end
        m0_wait  = ($urandom_range(0, 3) == 0);
        m0_rdv   = 1'($urandom);
        m0_rdata = $urandom;
        rest     = (rst_odds > 0) && ($urandom_range(1, rst_odds) == 1);
    endtask

    task automatic drive_tie();
        for (int i = 0; i < 2; i++) begin
            s_addr[i] = 32'h1000 * (i + 1);
            s_be[i]   = 4'hf;
            s_wd[i]   = $urandom;
            s_bc[i]   = 8'd2;
            s_rd[i]   = 1'b0;
            s_wr[i]   = 1'b1;
            s_beg[i]  = 1'b1;
        end
        m0_wait  = 1'b0;
        m0_rdv   = 1'($urandom);
        m0_rdata = $urandom;
        rest     = 1'b0;
    endtask

    task automatic run_cycle(input int mode);
        @(posedge clk);
        #1;
        case (mode)
            0: begin drive_random(0); rest = 1'b1; end
            1: drive_tie();
            default: drive_random(250);
        endcase
        #4;
        compare_outputs();
        model_step();
    endtask

    int exp_grant [4];

    initial begin
        drive_random(0);
        rest = 1'b1;
        for (int c = 0; c < 4; c++) run_cycle(0);

        // Both requesters writing continuously with 2-beat bursts.
        grants.delete();
        for (int c = 0; c < 16; c++) run_cycle(1);
`ifdef CACHE_ARB_RR_EN
        exp_grant = '{0, 1, 0, 1};
`else
        exp_grant = '{0, 0, 0, 0};
`endif
        chk("grant_count_ok", 128'(grants.size() >= 4), 128'(1));
        for (int k = 0; k < 4; k++) begin
            if (k < grants.size()) chk($sformatf("grant%0d", k), 128'(grants[k]), 128'(exp_grant[k]));
        end

        for (int c = 0; c < 4000; c++) run_cycle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
